// File: rtl/synaptic_accumulator.sv
// rtl/synaptic_accumulator.sv - single-neuron synaptic integrator: spike FIFO, parallel slot match,
// saturating accumulator and timestep publisher.
module synaptic_accumulator #(
  parameter int ADDR_W          = 12,
  parameter int WEIGHT_W        = 16,
  parameter int ACC_W           = 24,
  parameter int FAN_IN          = 5,
  parameter int FIFO_DEPTH      = 4,
  parameter int TIMESTEP_CYCLES = 4,
  localparam int IDX_W          = (FAN_IN > 1) ? $clog2(FAN_IN) : 1
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                en,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [WEIGHT_W-1:0] cfg_weight,
  input  logic                cfg_valid,
  input  logic                spike_valid,
  input  logic [ADDR_W-1:0]   spike_addr,
  output logic                spike_ready,
  output logic [ACC_W-1:0]    acc_out,
  output logic                acc_out_valid,
  output logic                sat_flag,
  output logic [7:0]          match_count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(TIMESTEP_CYCLES);
  localparam logic [IDX_W:0]   FAN_IN_L  = (IDX_W+1)'(FAN_IN);
  localparam logic [PTR_W:0]   DEPTH_L   = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(TIMESTEP_CYCLES - 1);
  localparam logic [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {ST_CONFIG, ST_RUN} state_t;

  state_t              state;
  logic [CNT_W-1:0]    step_cnt;
  logic [ACC_W-1:0]    acc;
  logic                sat;
  logic [7:0]          mcnt;

  logic [ADDR_W-1:0]   slot_addr   [FAN_IN];
  logic [WEIGHT_W-1:0] slot_weight [FAN_IN];
  logic [FAN_IN-1:0]   slot_valid;

  logic [ADDR_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [PTR_W:0]      fifo_count;

  logic                push, pop, hit, take, ovf, boundary;
  logic [WEIGHT_W-1:0] hit_weight;
  logic [ACC_W:0]      sum;
  logic [ACC_W-1:0]    acc_next;
  logic                sat_next;
  logic [7:0]          mcnt_next;
  logic [CNT_W-1:0]    eff_cnt;

  // Ready depends only on registered count, so a full FIFO never sees push and pop together.
  assign spike_ready = (fifo_count != DEPTH_L);
  assign push        = spike_valid && spike_ready;
  assign pop         = en && (fifo_count != '0);

  always_comb begin
    hit        = 1'b0;
    hit_weight = '0;
    // Descending scan so the lowest-index matching slot wins.
    for (int i = FAN_IN - 1; i >= 0; i--) begin
      if (slot_valid[i] && (slot_addr[i] == fifo_mem[rd_ptr])) begin
        hit        = 1'b1;
        hit_weight = slot_weight[i];
      end
    end
  end

  always_comb begin
    take      = pop && hit;
    sum       = {acc[ACC_W-1], acc} + {{(ACC_W-WEIGHT_W+1){hit_weight[WEIGHT_W-1]}}, hit_weight};
    ovf       = take && (sum[ACC_W] != sum[ACC_W-1]);
    acc_next  = acc;
    if (ovf)       acc_next = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    else if (take) acc_next = sum[ACC_W-1:0];
    sat_next  = sat | ovf;
    mcnt_next = (take && (mcnt != 8'hFF)) ? mcnt + 8'd1 : mcnt;
    // The first RUN cycle after configuration counts as step 0.
    eff_cnt   = (state == ST_RUN) ? step_cnt : '0;
    boundary  = en && (eff_cnt == LAST_STEP);
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= spike_addr;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= ST_CONFIG;
      step_cnt      <= '0;
      acc           <= '0;
      sat           <= 1'b0;
      mcnt          <= '0;
      acc_out       <= '0;
      acc_out_valid <= 1'b0;
      sat_flag      <= 1'b0;
      match_count   <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      slot_valid    <= '0;
      for (int i = 0; i < FAN_IN; i++) begin
        slot_addr[i]   <= '0;
        slot_weight[i] <= '0;
      end
    end else begin
      state         <= en ? ST_RUN : ST_CONFIG;
      acc_out_valid <= boundary;
      if (en) step_cnt <= boundary ? '0 : eff_cnt + CNT_W'(1);

      if (boundary) begin
        acc_out     <= acc_next;
        sat_flag    <= sat_next;
        match_count <= mcnt_next;
        acc         <= '0;
        sat         <= 1'b0;
        mcnt        <= '0;
      end else begin
        acc  <= acc_next;
        sat  <= sat_next;
        mcnt <= mcnt_next;
      end

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
        default: fifo_count <= fifo_count;
      endcase

      if (!en && cfg_we && ({1'b0, cfg_idx} < FAN_IN_L)) begin
        slot_addr[cfg_idx]   <= cfg_addr;
        slot_weight[cfg_idx] <= cfg_weight;
        slot_valid[cfg_idx]  <= cfg_valid;
      end
    end
  end
endmodule

// File: tb/tb_synaptic_accumulator.sv
// tb/tb_synaptic_accumulator.sv - scenario tasks plus a cycle model feeding a result scoreboard.
module tb_synaptic_accumulator;
  localparam int ADDR_W = 12, WEIGHT_W = 16, ACC_W = 16, FAN_IN = 8, DEPTH = 4, TS = 8;
  localparam int AMAX = (1 << (ACC_W - 1)) - 1;
  localparam int AMIN = -(1 << (ACC_W - 1));

  logic                CLK = 1'b0, RESET_N = 1'b0, en = 1'b0, cfg_we = 1'b0, cfg_valid = 1'b0;
  logic [2:0]          cfg_idx = '0;
  logic [ADDR_W-1:0]   cfg_addr = '0, spike_addr = '0;
  logic [WEIGHT_W-1:0] cfg_weight = '0;
  logic                spike_valid = 1'b0, spike_ready, acc_out_valid, sat_flag;
  logic [ACC_W-1:0]    acc_out;
  logic [7:0]          match_count;

  int checks = 0, errors = 0;

  typedef struct { int acc; bit sat; int mc; } exp_t;
  exp_t exp_q[$];

  int  m_fifo[$];
  bit  m_run, m_sat;
  int  m_cnt, m_acc, m_mc;
  bit  m_sv[FAN_IN];
  int  m_sa[FAN_IN], m_sw[FAN_IN];

  synaptic_accumulator #(.ADDR_W(ADDR_W), .WEIGHT_W(WEIGHT_W), .ACC_W(ACC_W), .FAN_IN(FAN_IN),
                         .FIFO_DEPTH(DEPTH), .TIMESTEP_CYCLES(TS)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .en(en), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_weight(cfg_weight), .cfg_valid(cfg_valid),
    .spike_valid(spike_valid), .spike_addr(spike_addr), .spike_ready(spike_ready),
    .acc_out(acc_out), .acc_out_valid(acc_out_valid), .sat_flag(sat_flag),
    .match_count(match_count));

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (!RESET_N) begin
      m_fifo.delete(); exp_q.delete();
      m_run = 0; m_cnt = 0; m_acc = 0; m_mc = 0; m_sat = 0;
      for (int i = 0; i < FAN_IN; i++) begin m_sv[i] = 0; m_sa[i] = 0; m_sw[i] = 0; end
    end else begin
      bit do_push; int c, a, s; exp_t e;
      do_push = spike_valid && (m_fifo.size() < DEPTH);
      if (en) begin
        c = m_run ? m_cnt : 0;
        if (m_fifo.size() > 0) begin
          a = m_fifo.pop_front();
          for (int i = 0; i < FAN_IN; i++) begin
            if (m_sv[i] && m_sa[i] == a) begin
              s = m_acc + m_sw[i];
              if (s > AMAX) begin s = AMAX; m_sat = 1; end
              if (s < AMIN) begin s = AMIN; m_sat = 1; end
              m_acc = s;
              if (m_mc < 255) m_mc++;
              break;
            end
          end
        end
        if (c == TS - 1) begin
          e.acc = m_acc; e.sat = m_sat; e.mc = m_mc;
          exp_q.push_back(e);
          m_acc = 0; m_sat = 0; m_mc = 0; m_cnt = 0;
        end else m_cnt = c + 1;
      end
      m_run = en;
      if (do_push) m_fifo.push_back(int'(spike_addr));
      if (!en && cfg_we && int'(cfg_idx) < FAN_IN) begin
        m_sv[cfg_idx] = cfg_valid;
        m_sa[cfg_idx] = int'(cfg_addr);
        m_sw[cfg_idx] = int'($signed(cfg_weight));
      end
    end
  end

  always @(negedge CLK) begin
    if (RESET_N) begin
      checks++;
      if (spike_ready !== (m_fifo.size() < DEPTH)) begin
        errors++; $display("FAIL sb_ready got %b want %b at %0t", spike_ready, m_fifo.size() < DEPTH, $time);
      end
      if (acc_out_valid || exp_q.size() > 0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL sb_unexpected_pulse got acc %0d want none at %0t", $signed(acc_out), $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (acc_out_valid !== 1'b1 || int'($signed(acc_out)) !== e.acc || sat_flag !== e.sat ||
              int'(match_count) !== e.mc) begin
            errors++;
            $display("FAIL sb_result got v=%b acc=%0d sat=%b mc=%0d want v=1 acc=%0d sat=%b mc=%0d at %0t",
                     acc_out_valid, $signed(acc_out), sat_flag, match_count, e.acc, e.sat, e.mc, $time);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic cfg_slot(input int idx, input int addr, input int w, input bit v);
    cfg_we = 1; cfg_idx = idx[2:0]; cfg_addr = addr[ADDR_W-1:0]; cfg_weight = w[WEIGHT_W-1:0]; cfg_valid = v;
    tick();
    cfg_we = 0;
  endtask

  task automatic push_spike(input int addr);
    bit took = 0;
    spike_valid = 1; spike_addr = addr[ADDR_W-1:0];
    for (int i = 0; i < 200 && !took; i++) begin
      @(negedge CLK); took = spike_ready;
      tick();
    end
    spike_valid = 0;
    if (!took) begin checks++; errors++; $display("FAIL push_timeout got no ready want ready addr %0d", addr); end
  endtask

  task automatic wait_pulse();
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (acc_out_valid) return;
    end
    checks++; errors++; $display("FAIL pulse_timeout got no acc_out_valid want pulse at %0t", $time);
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (acc_out !== '0)      begin errors++; $display("FAIL rst_acc got %0d want 0", acc_out); end
    checks++; if (acc_out_valid !== 0) begin errors++; $display("FAIL rst_valid got %b want 0", acc_out_valid); end
    checks++; if (sat_flag !== 0)      begin errors++; $display("FAIL rst_sat got %b want 0", sat_flag); end
    checks++; if (match_count !== 0)   begin errors++; $display("FAIL rst_mc got %0d want 0", match_count); end
    checks++; if (spike_ready !== 1)   begin errors++; $display("FAIL rst_ready got %b want 1", spike_ready); end
    RESET_N = 1;
    tick();
  endtask

  task automatic test_basic();
    en = 0;
    cfg_slot(3, 3, 100, 1); cfg_slot(4, 4, -30, 1); cfg_slot(5, 5, 50, 1);
    cfg_slot(6, 6, 999, 0); cfg_slot(7, 7, 7, 1);
    en = 1;
    for (int a = 3; a <= 7; a++) push_spike(a);
    wait_pulse();
    checks++; if (acc_out !== 16'd127)    begin errors++; $display("FAIL basic_acc got %0d want 127", $signed(acc_out)); end
    checks++; if (match_count !== 8'd4)   begin errors++; $display("FAIL basic_mc got %0d want 4", match_count); end
    checks++; if (sat_flag !== 0)         begin errors++; $display("FAIL basic_sat got %b want 0", sat_flag); end
    @(negedge CLK);
    checks++; if (acc_out_valid !== 0)    begin errors++; $display("FAIL basic_pulse_width got %b want 0", acc_out_valid); end
    wait_pulse();
    checks++; if (acc_out !== '0)         begin errors++; $display("FAIL basic_empty_acc got %0d want 0", $signed(acc_out)); end
    en = 0;
  endtask

  task automatic test_saturation();
    tick();
    cfg_slot(2, 2, 20000, 1);
    en = 1;
    repeat (3) push_spike(2);
    wait_pulse();
    checks++; if (acc_out !== 16'h7FFF || sat_flag !== 1)
      begin errors++; $display("FAIL sat_pos got %0d/%b want 32767/1", $signed(acc_out), sat_flag); end
    en = 0;
    tick();
    cfg_slot(2, 2, -20000, 1);
    en = 1;
    repeat (2) push_spike(2);
    wait_pulse();
    checks++; if (acc_out !== 16'h8000 || sat_flag !== 1)
      begin errors++; $display("FAIL sat_neg got %0d/%b want -32768/1", $signed(acc_out), sat_flag); end
    en = 0;
  endtask

  task automatic test_backpressure();
    bit took = 0;
    tick();
    push_spike(3); push_spike(5); push_spike(7); push_spike(3);
    @(negedge CLK);
    checks++; if (spike_ready !== 0) begin errors++; $display("FAIL bp_full_ready got %b want 0", spike_ready); end
    spike_valid = 1; spike_addr = 12'd5;
    repeat (3) tick();
    @(negedge CLK);
    checks++; if (spike_ready !== 0) begin errors++; $display("FAIL bp_held_ready got %b want 0", spike_ready); end
    tick();
    en = 1;
    for (int i = 0; i < 20 && !took; i++) begin
      @(negedge CLK); took = spike_ready;
      tick();
    end
    spike_valid = 0;
    checks++; if (!took) begin errors++; $display("FAIL bp_fifth got not accepted want accepted"); end
    wait_pulse();
    checks++; if (acc_out !== 16'd307 || match_count !== 8'd5)
      begin errors++; $display("FAIL bp_acc got %0d/%0d want 307/5", $signed(acc_out), match_count); end
    en = 0;
  endtask

  task automatic test_dup_miss();
    tick();
    cfg_slot(0, 9, 10, 1); cfg_slot(1, 9, 20, 1);
    en = 1;
    cfg_slot(0, 9, 500, 1);
    push_spike(9); push_spike(42);
    wait_pulse();
    checks++; if (acc_out !== 16'd10 || match_count !== 8'd1)
      begin errors++; $display("FAIL dup_miss got %0d/%0d want 10/1", $signed(acc_out), match_count); end
    en = 0;
  endtask

  task automatic test_pause();
    tick();
    en = 1;
    push_spike(3);
    tick();
    en = 0;
    repeat (4) tick();
    en = 1;
    push_spike(5);
    wait_pulse();
    checks++; if (acc_out !== 16'd150 || match_count !== 8'd2)
      begin errors++; $display("FAIL pause_hold got %0d/%0d want 150/2", $signed(acc_out), match_count); end
    en = 0;
  endtask

  task automatic test_boundary();
    tick();
    en = 1;
    repeat (6) tick();
    push_spike(3);
    push_spike(5);
    wait_pulse();
    checks++; if (acc_out !== 16'd100 || match_count !== 8'd1)
      begin errors++; $display("FAIL bnd_last got %0d/%0d want 100/1", $signed(acc_out), match_count); end
    wait_pulse();
    checks++; if (acc_out !== 16'd50)
      begin errors++; $display("FAIL bnd_next got %0d want 50", $signed(acc_out)); end
    en = 0;
  endtask

  task automatic test_reset_mid();
    tick();
    en = 1;
    push_spike(3); push_spike(5);
    tick();
    en = 0;
    push_spike(7); push_spike(7);
    RESET_N = 0;
    #1;
    checks++; if (acc_out !== '0 || acc_out_valid !== 0 || match_count !== 0 || spike_ready !== 1)
      begin errors++; $display("FAIL mid_rst got acc=%0d v=%b mc=%0d rdy=%b want 0/0/0/1",
                               $signed(acc_out), acc_out_valid, match_count, spike_ready); end
    tick();
    RESET_N = 1;
    tick();
    en = 1;
    push_spike(3);
    wait_pulse();
    checks++; if (acc_out !== '0 || match_count !== 0)
      begin errors++; $display("FAIL mid_rst_slots got %0d/%0d want 0/0", $signed(acc_out), match_count); end
    en = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_dup_miss();
    test_pause();
    test_boundary();
    test_reset_mid();
    repeat (3) tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drain got %0d pending want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
